// File: rtl/vblank_scheduler.sv
// rtl/vblank_scheduler.sv - vertical-blanking arbiter for the shared game-state update port
//
// Grants the game-state update port to one of three requesters (paddle, ball,
// bricks) during vertical blanking. Each requester is served at most once per
// frame. Grants are issued in round-robin order and are revoked by a matching
// done pulse, by a timeout, or by the end of the frame.
//
// Ports:
//   clk_100MHz  in   1   system clock, rising-edge
//   reset_n     in   1   asynchronous active-low reset
//   p_tick      in   1   one-cycle pixel strobe
//   x, y        in  10   current horizontal / vertical count
//   req         in   3   level request per requester (0 paddle, 1 ball, 2 bricks)
//   done        in   3   one-cycle completion pulse per requester
//   gnt         out  3   registered one-hot grant, zero when idle
//   busy        out  1   high while any grant is active
//   served      out  3   requesters granted and completed this frame
//   frame_cnt   out 16   frames elapsed since reset, wrapping
//   overrun     out  1   pulse: grant revoked at end of frame
//   timeout_err out  1   pulse: grant revoked by timeout
module vblank_scheduler #(
  parameter int HMAX    = 799,
  parameter int VD      = 480,
  parameter int VMAX    = 524,
  parameter int TIMEOUT = 2000
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic [2:0]  served,
  output logic [15:0] frame_cnt,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Timeout fires on the p_tick that would bring the counter to TIMEOUT,
  // so the grant is gone in the cycle right after that pulse.
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [9:0] HMAX_L = 10'(HMAX);
  localparam logic [9:0] VD_L   = 10'(VD);
  localparam logic [9:0] VMAX_L = 10'(VMAX);

  typedef enum logic [1:0] {
    WAIT_VB    = 2'd0,
    ARB        = 2'd1,
    BUSY       = 2'd2,
    DONE_FRAME = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      gnt_nxt, served_nxt;
  logic [1:0]      ptr, ptr_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;
  logic            overrun_nxt, terr_nxt;

  logic            vb_start, frame_end;
  logic [2:0]      pending;
  logic [1:0]      pick_idx, gnt_idx;
  logic            done_hit, timeout_hit;

  assign vb_start  = p_tick && (x == 10'd0) && (y == VD_L);
  assign frame_end = p_tick && (x == HMAX_L) && (y == VMAX_L);
  assign pending   = req & ~served;
  assign done_hit  = |(done & gnt);
  assign timeout_hit = p_tick && (tcnt == TLAST);
  assign busy      = |gnt;

  // First pending index strictly after the last granted one, wrapping over
  // the three requesters; the last-granted index itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
    logic [2:0] cand;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cand = {1'b0, last} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && pend[cand[1:0]]) begin
        rr_pick = cand[1:0];
        found   = 1'b1;
      end
    end
  endfunction

  assign pick_idx = rr_pick(pending, ptr);
  assign gnt_idx  = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    served_nxt  = served;
    ptr_nxt     = ptr;
    tcnt_nxt    = tcnt;
    overrun_nxt = 1'b0;
    terr_nxt    = 1'b0;
    case (state)
      WAIT_VB: begin
        if (vb_start) begin
          served_nxt = 3'b000;
          state_nxt  = ARB;
        end
      end
      ARB: begin
        // End of frame wins over starting a new grant.
        if (frame_end) begin
          state_nxt = WAIT_VB;
        end else if (|pending) begin
          gnt_nxt   = 3'b001 << pick_idx;
          tcnt_nxt  = '0;
          state_nxt = BUSY;
        end else begin
          state_nxt = DONE_FRAME;
        end
      end
      BUSY: begin
        // A matching done beats both timeout and end of frame; stray done
        // bits for other requesters fall through untouched.
        if (done_hit) begin
          gnt_nxt    = 3'b000;
          served_nxt = served | gnt;
          ptr_nxt    = gnt_idx;
          state_nxt  = frame_end ? WAIT_VB : ARB;
        end else if (frame_end) begin
          gnt_nxt     = 3'b000;
          overrun_nxt = 1'b1;
          state_nxt   = WAIT_VB;
        end else if (timeout_hit) begin
          gnt_nxt    = 3'b000;
          served_nxt = served | gnt;
          ptr_nxt    = gnt_idx;
          terr_nxt   = 1'b1;
          state_nxt  = ARB;
        end else if (p_tick) begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      DONE_FRAME: begin
        if (frame_end) state_nxt = WAIT_VB;
      end
      default: begin
        state_nxt = WAIT_VB;
        gnt_nxt   = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_VB;
      gnt         <= 3'b000;
      served      <= 3'b000;
      ptr         <= 2'd2;
      tcnt        <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      served      <= served_nxt;
      ptr         <= ptr_nxt;
      tcnt        <= tcnt_nxt;
      overrun     <= overrun_nxt;
      timeout_err <= terr_nxt;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= 16'd0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vblank_scheduler.sv
// tb/tb_vblank_scheduler.sv - self-checking bench for vblank_scheduler
module tb_vblank_scheduler;

  logic        clk_100MHz = 1'b0;
  logic        reset_n;
  logic        p_tick;
  logic [9:0]  x, y;
  logic [2:0]  req, done;
  logic [2:0]  gnt, served;
  logic        busy, overrun, timeout_err;
  logic [15:0] frame_cnt;

  always #5 clk_100MHz = ~clk_100MHz;

  vblank_scheduler #(.HMAX(799), .VD(480), .VMAX(524), .TIMEOUT(4)) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .x          (x),
    .y          (y),
    .req        (req),
    .done       (done),
    .gnt        (gnt),
    .busy       (busy),
    .served     (served),
    .frame_cnt  (frame_cnt),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  // K_IDLE: no tick; K_VB: vblank start; K_FE: frame end; K_TICK: plain tick;
  // K_LATE: no tick at x=790,y=524; K_NEAR: tick at x=0,y=479 (not vblank)
  typedef enum int {K_IDLE, K_VB, K_FE, K_TICK, K_LATE, K_NEAR} kind_t;

  typedef struct {
    kind_t       k;
    logic [2:0]  req;
    logic [2:0]  done;
    int          rep;
    logic [2:0]  g;
    logic [2:0]  s;
    logic        ov;
    logic        te;
    logic [15:0] fc;
  } vec_t;

  typedef struct {
    logic [2:0]  g;
    logic [2:0]  s;
    logic        ov;
    logic        te;
    logic [15:0] fc;
    string       tag;
  } exp_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(kind_t k, logic [2:0] r, logic [2:0] d, int rep,
                              logic [2:0] g, logic [2:0] s, logic ov, logic te, int fc);
    vec_t v;
    v.k = k; v.req = r; v.done = d; v.rep = rep;
    v.g = g; v.s = s; v.ov = ov; v.te = te; v.fc = 16'(fc);
    return v;
  endfunction

  task automatic drive(kind_t k, logic [2:0] r, logic [2:0] d);
    case (k)
      K_VB:    begin p_tick = 1'b1; x = 10'd0;   y = 10'd480; end
      K_FE:    begin p_tick = 1'b1; x = 10'd799; y = 10'd524; end
      K_TICK:  begin p_tick = 1'b1; x = 10'd5;   y = 10'd10;  end
      K_LATE:  begin p_tick = 1'b0; x = 10'd790; y = 10'd524; end
      K_NEAR:  begin p_tick = 1'b1; x = 10'd0;   y = 10'd479; end
      default: begin p_tick = 1'b0; x = 10'd5;   y = 10'd10;  end
    endcase
    req  = r;
    done = d;
  endtask

  task automatic check(exp_t e);
    n_vec++;
    if (gnt !== e.g || busy !== (|e.g) || served !== e.s || overrun !== e.ov ||
        timeout_err !== e.te || frame_cnt !== e.fc) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b busy=%b served=%b ov=%b te=%b fc=%0d, want gnt=%b busy=%b served=%b ov=%b te=%b fc=%0d",
               e.tag, gnt, busy, served, overrun, timeout_err, frame_cnt,
               e.g, |e.g, e.s, e.ov, e.te, e.fc);
    end
  endtask

  task automatic run(vec_t v, string tag);
    exp_t e, got;
    for (int i = 0; i < v.rep; i++) begin
      @(negedge clk_100MHz);
      drive(v.k, v.req, v.done);
      e.g = v.g; e.s = v.s; e.ov = v.ov; e.te = v.te; e.fc = v.fc;
      e.tag = $sformatf("%s.%0d", tag, i);
      sb.push_back(e);
      @(posedge clk_100MHz);
      #1;
      got = sb.pop_front();
      check(got);
    end
  endtask

  function automatic exp_t zero_exp(string tag);
    exp_t e;
    e.g = 3'b000; e.s = 3'b000; e.ov = 1'b0; e.te = 1'b0; e.fc = 16'd0; e.tag = tag;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Full frame, all three requesting, done 10 cycles after each grant.
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 2, 3'b000, 3'b000, 0, 0, 0));
    tbl_a.push_back(mk(K_VB,   3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 1, 3'b001, 3'b000, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 9, 3'b001, 3'b000, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b001, 1, 3'b000, 3'b001, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 1, 3'b010, 3'b001, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 9, 3'b010, 3'b001, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b010, 1, 3'b000, 3'b011, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 1, 3'b100, 3'b011, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 9, 3'b100, 3'b011, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b100, 1, 3'b000, 3'b111, 0, 0, 0));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 3, 3'b000, 3'b111, 0, 0, 0));
    tbl_a.push_back(mk(K_FE,   3'b111, 3'b000, 1, 3'b000, 3'b111, 0, 0, 1));
    // Pointer at 2, req=011.
    tbl_a.push_back(mk(K_VB,   3'b011, 3'b000, 1, 3'b000, 3'b000, 0, 0, 1));
    tbl_a.push_back(mk(K_IDLE, 3'b011, 3'b000, 1, 3'b001, 3'b000, 0, 0, 1));
    tbl_a.push_back(mk(K_IDLE, 3'b011, 3'b001, 1, 3'b000, 3'b001, 0, 0, 1));
    tbl_a.push_back(mk(K_IDLE, 3'b011, 3'b000, 1, 3'b010, 3'b001, 0, 0, 1));
    tbl_a.push_back(mk(K_IDLE, 3'b011, 3'b010, 1, 3'b000, 3'b011, 0, 0, 1));
    tbl_a.push_back(mk(K_IDLE, 3'b011, 3'b000, 1, 3'b000, 3'b011, 0, 0, 1));
    tbl_a.push_back(mk(K_FE,   3'b011, 3'b000, 1, 3'b000, 3'b011, 0, 0, 2));
    // Leave the pointer at 0.
    tbl_a.push_back(mk(K_VB,   3'b001, 3'b000, 1, 3'b000, 3'b000, 0, 0, 2));
    tbl_a.push_back(mk(K_IDLE, 3'b001, 3'b000, 1, 3'b001, 3'b000, 0, 0, 2));
    tbl_a.push_back(mk(K_IDLE, 3'b001, 3'b001, 1, 3'b000, 3'b001, 0, 0, 2));
    tbl_a.push_back(mk(K_IDLE, 3'b001, 3'b000, 1, 3'b000, 3'b001, 0, 0, 2));
    tbl_a.push_back(mk(K_FE,   3'b001, 3'b000, 1, 3'b000, 3'b001, 0, 0, 3));
    // Pointer at 0, req=101: bricks first, then paddle.
    tbl_a.push_back(mk(K_VB,   3'b101, 3'b000, 1, 3'b000, 3'b000, 0, 0, 3));
    tbl_a.push_back(mk(K_IDLE, 3'b101, 3'b000, 1, 3'b100, 3'b000, 0, 0, 3));
    tbl_a.push_back(mk(K_IDLE, 3'b101, 3'b100, 1, 3'b000, 3'b100, 0, 0, 3));
    tbl_a.push_back(mk(K_IDLE, 3'b101, 3'b000, 1, 3'b001, 3'b100, 0, 0, 3));
    tbl_a.push_back(mk(K_IDLE, 3'b101, 3'b001, 1, 3'b000, 3'b101, 0, 0, 3));
    tbl_a.push_back(mk(K_IDLE, 3'b101, 3'b000, 1, 3'b000, 3'b101, 0, 0, 3));
    tbl_a.push_back(mk(K_FE,   3'b101, 3'b000, 1, 3'b000, 3'b101, 0, 0, 4));
    // Timeout on ball with req dropped mid-grant, then arbitration continues.
    tbl_a.push_back(mk(K_VB,   3'b010, 3'b000, 1, 3'b000, 3'b000, 0, 0, 4));
    tbl_a.push_back(mk(K_IDLE, 3'b010, 3'b000, 1, 3'b010, 3'b000, 0, 0, 4));
    tbl_a.push_back(mk(K_TICK, 3'b000, 3'b000, 3, 3'b010, 3'b000, 0, 0, 4));
    tbl_a.push_back(mk(K_TICK, 3'b000, 3'b000, 1, 3'b000, 3'b010, 0, 1, 4));
    // Grant at y=524, x=790, no done: overrun at frame end.
    tbl_a.push_back(mk(K_LATE, 3'b110, 3'b000, 3, 3'b100, 3'b010, 0, 0, 4));
    tbl_a.push_back(mk(K_FE,   3'b110, 3'b000, 1, 3'b000, 3'b010, 1, 0, 5));
    tbl_a.push_back(mk(K_IDLE, 3'b110, 3'b000, 1, 3'b000, 3'b010, 0, 0, 5));
    tbl_a.push_back(mk(K_VB,   3'b010, 3'b000, 1, 3'b000, 3'b000, 0, 0, 5));
    // Stray done ignored; done together with frame end is a clean completion.
    tbl_a.push_back(mk(K_IDLE, 3'b010, 3'b000, 1, 3'b010, 3'b000, 0, 0, 5));
    tbl_a.push_back(mk(K_IDLE, 3'b010, 3'b100, 1, 3'b010, 3'b000, 0, 0, 5));
    tbl_a.push_back(mk(K_FE,   3'b010, 3'b010, 1, 3'b000, 3'b010, 0, 0, 6));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 2, 3'b000, 3'b010, 0, 0, 6));
    // Frame end in ARB beats a pending grant.
    tbl_a.push_back(mk(K_VB,   3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 0, 6));
    tbl_a.push_back(mk(K_FE,   3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 0, 7));
    tbl_a.push_back(mk(K_IDLE, 3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 0, 7));
    tbl_a.push_back(mk(K_VB,   3'b100, 3'b000, 1, 3'b000, 3'b000, 0, 0, 7));
    tbl_a.push_back(mk(K_IDLE, 3'b100, 3'b000, 1, 3'b100, 3'b000, 0, 0, 7));

    // After a mid-grant reset: nothing until a real vblank start.
    tbl_b.push_back(mk(K_IDLE, 3'b111, 3'b000, 2, 3'b000, 3'b000, 0, 0, 0));
    tbl_b.push_back(mk(K_NEAR, 3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 0, 0));
    tbl_b.push_back(mk(K_FE,   3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 0, 1));
    tbl_b.push_back(mk(K_IDLE, 3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 0, 1));
    tbl_b.push_back(mk(K_VB,   3'b111, 3'b000, 1, 3'b000, 3'b000, 0, 0, 1));
    tbl_b.push_back(mk(K_IDLE, 3'b111, 3'b000, 1, 3'b001, 3'b000, 0, 0, 1));
    tbl_b.push_back(mk(K_IDLE, 3'b111, 3'b001, 1, 3'b000, 3'b001, 0, 0, 1));
    tbl_b.push_back(mk(K_IDLE, 3'b111, 3'b000, 1, 3'b010, 3'b001, 0, 0, 1));

    reset_n = 1'b0;
    drive(K_IDLE, 3'b111, 3'b000);
    repeat (2) @(posedge clk_100MHz);
    #1;
    check(zero_exp("reset_state"));
    @(negedge clk_100MHz);
    reset_n = 1'b1;

    foreach (tbl_a[i]) run(tbl_a[i], $sformatf("a%0d", i));

    // Asynchronous reset while bricks hold the grant.
    @(negedge clk_100MHz);
    #2 reset_n = 1'b0;
    #1 check(zero_exp("reset_async_midgrant"));
    @(posedge clk_100MHz);
    #1 check(zero_exp("reset_held"));
    @(negedge clk_100MHz);
    reset_n = 1'b1;

    foreach (tbl_b[i]) run(tbl_b[i], $sformatf("b%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
